vehicle_dynamics_v2: RTL and testbench



---
 rtl/vehicle_dynamics_v2.sv | 183 ++++++++++++++++++
 tb/tb_vehicle_dynamics_v2.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_dynamics_v2.sv
// Vehicle speed integrator with automatic gearbox, cruise control, registered RPM
// and once-per-second odometer/fuel/temperature bookkeeping.
module vehicle_dynamics_v2 #(
  parameter int unsigned SPEED_W     = 8,
  parameter int unsigned MAX_SPEED   = 250,
  parameter int unsigned REV_LIMIT   = 50,
  parameter int unsigned DEADZONE    = 10,
  parameter int unsigned HARD_DEC    = 8,
  parameter int unsigned NORM_DEC    = 3,
  parameter int unsigned ESS_SPEED   = 50,
  parameter int unsigned CRUISE_MIN  = 30,
  parameter int unsigned SHIFT_HOLD  = 4,
  parameter int unsigned IDLE_RPM    = 800,
  parameter int unsigned RPM_MAX     = 8000,
  parameter int unsigned FUEL_PERIOD = 3,
  parameter int unsigned ODO_PERIOD  = 10,
  parameter int unsigned TEMP_MAX    = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               engine_on,
  input  logic               tick_1sec,
  input  logic               tick_speed,
  input  logic [3:0]         current_gear,
  input  logic [7:0]         adc_accel,
  input  logic               is_brake_normal,
  input  logic               is_brake_hard,
  input  logic               cruise_set,
  input  logic               cruise_cancel,
  output logic [SPEED_W-1:0] speed,
  output logic [13:0]        rpm,
  output logic [2:0]         engaged_gear,
  output logic               shift_pulse,
  output logic               cruise_active,
  output logic [SPEED_W-1:0] cruise_target,
  output logic [7:0]         fuel,
  output logic               fuel_empty,
  output logic [7:0]         temp,
  output logic [31:0]        odometer_raw,
  output logic               ess_trigger
);
  localparam int unsigned SW2 = SPEED_W + 2;
  localparam logic [3:0] SEL_R = 4'd6;
  localparam logic [3:0] SEL_D = 4'd12;
  localparam logic [2:0] GEAR_NONE = 3'd0;
  localparam logic [2:0] GEAR_1    = 3'd1;
  localparam logic [SPEED_W-1:0] SPD_ONE = SPEED_W'(1);

  logic [SPEED_W-1:0] speed_q, speed_d, ctgt_q, ctgt_d;
  logic [13:0]        rpm_q, rpm_d, rpm_next;
  logic [2:0]         gear_q, gear_d;
  logic [3:0]         hold_q, hold_d;
  logic               was_d_q, was_d_d, shift_q, shift_d, cact_q, cact_d, ess_q, ess_d;
  logic [7:0]         fuel_q, fuel_d, temp_q, temp_d;
  logic [7:0]         fuel_tmr_q, fuel_tmr_d, odo_cnt_q, odo_cnt_d;
  logic [31:0]        odo_q, odo_d;

  logic               is_d, is_r, up_ok, dn_ok;
  logic [7:0]         eacc;
  logic [SW2-1:0]     power, resist;
  logic [31:0]        spd32, ceil32, up_thr, dn_thr, rpm_base, rpm_low, rpm_slope, rpm_calc;

  assign is_d   = (current_gear == SEL_D);
  assign is_r   = (current_gear == SEL_R);
  assign eacc   = (adc_accel > 8'(DEADZONE) && fuel_q != 8'd0) ? adc_accel : 8'd0;
  assign spd32  = 32'(speed_q);
  assign ceil32 = is_r ? REV_LIMIT : MAX_SPEED;
  assign power  = is_d ? SW2'(eacc) : (is_r ? SW2'(eacc >> 1) : '0);
  assign resist = SW2'(speed_q >> 2) + SW2'(2);

  // Per-gear shift thresholds and RPM curve (base, low, slope).
  always_comb begin
    up_ok = 1'b0; dn_ok = 1'b0; up_thr = '0; dn_thr = '0;
    rpm_base = IDLE_RPM; rpm_low = '0; rpm_slope = '0;
    case (gear_q)
      3'd1: begin up_ok = 1'b1; up_thr = 30; rpm_base = 800; rpm_slope = 90; end
      3'd2: begin up_ok = 1'b1; up_thr = 60; dn_ok = 1'b1; dn_thr = 25;
                  rpm_base = 1500; rpm_low = 30; rpm_slope = 70; end
      3'd3: begin up_ok = 1'b1; up_thr = 90; dn_ok = 1'b1; dn_thr = 55;
                  rpm_base = 1500; rpm_low = 60; rpm_slope = 50; end
      3'd4: begin up_ok = 1'b1; up_thr = 130; dn_ok = 1'b1; dn_thr = 85;
                  rpm_base = 1600; rpm_low = 90; rpm_slope = 40; end
      3'd5: begin up_ok = 1'b1; up_thr = 180; dn_ok = 1'b1; dn_thr = 125;
                  rpm_base = 1700; rpm_low = 130; rpm_slope = 30; end
      3'd6: begin dn_ok = 1'b1; dn_thr = 175;
                  rpm_base = 1800; rpm_low = 180; rpm_slope = 20; end
      default: ;
    endcase
  end

  always_comb begin
    if (gear_q == GEAR_NONE) rpm_calc = IDLE_RPM + 32'(eacc) * 32'd20;
    else rpm_calc = rpm_base + ((spd32 > rpm_low) ? (spd32 - rpm_low) : 32'd0) * rpm_slope;
    rpm_next = (rpm_calc > RPM_MAX) ? 14'(RPM_MAX) : rpm_calc[13:0];
  end

  always_comb begin
    speed_d = speed_q; rpm_d = rpm_q; gear_d = gear_q; hold_d = hold_q; was_d_d = was_d_q;
    shift_d = 1'b0; cact_d = cact_q; ctgt_d = ctgt_q; ess_d = ess_q;
    fuel_d = fuel_q; temp_d = temp_q; fuel_tmr_d = fuel_tmr_q; odo_cnt_d = odo_cnt_q; odo_d = odo_q;
    if (!engine_on) begin
      speed_d = '0; rpm_d = '0; gear_d = GEAR_NONE; hold_d = '0; was_d_d = 1'b0;
      cact_d = 1'b0; ctgt_d = '0; ess_d = 1'b0;
    end else begin
      rpm_d = rpm_next;
      if (tick_speed) begin
        if (is_brake_hard) begin
          ess_d   = (spd32 > ESS_SPEED);
          speed_d = (spd32 > HARD_DEC) ? speed_q - SPEED_W'(HARD_DEC) : '0;
        end else begin
          ess_d = 1'b0;
          if (is_brake_normal)
            speed_d = (spd32 > NORM_DEC) ? speed_q - SPEED_W'(NORM_DEC) : '0;
          else if (cact_q && eacc == 8'd0) begin
            if (speed_q < ctgt_q) speed_d = speed_q + SPD_ONE;
            else if (speed_q > ctgt_q) speed_d = speed_q - SPD_ONE;
          end else if (power > resist) begin
            if (spd32 < ceil32) speed_d = speed_q + SPD_ONE;
          end else if (power < resist && speed_q != '0)
            speed_d = speed_q - SPD_ONE;
        end
        // Gearbox: shifts only after the selector has been seen in D on a prior tick.
        was_d_d = is_d;
        if (is_r) begin
          gear_d = GEAR_1; hold_d = '0;
        end else if (!is_d) begin
          gear_d = GEAR_NONE; hold_d = '0;
        end else if (!was_d_q) begin
          gear_d = GEAR_1; hold_d = '0;
        end else if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else if (up_ok && spd32 >= up_thr) begin
          gear_d = gear_q + 3'd1; hold_d = 4'(SHIFT_HOLD); shift_d = 1'b1;
        end else if (dn_ok && spd32 < dn_thr) begin
          gear_d = gear_q - 3'd1; hold_d = 4'(SHIFT_HOLD); shift_d = 1'b1;
        end
      end
      if (cruise_cancel || is_brake_normal || is_brake_hard || !is_d) cact_d = 1'b0;
      else if (cruise_set && spd32 >= CRUISE_MIN) begin
        cact_d = 1'b1; ctgt_d = speed_q;
      end
      if (tick_1sec) begin
        if (32'(odo_cnt_q) == ODO_PERIOD - 1) begin
          odo_cnt_d = '0; odo_d = odo_q + 32'(speed_q);
        end else odo_cnt_d = odo_cnt_q + 8'd1;
        if (speed_q != '0 || 32'(rpm_q) > 32'd1000) begin
          if (32'(fuel_tmr_q) == FUEL_PERIOD - 1) begin
            fuel_tmr_d = '0;
            if (fuel_q != 8'd0) fuel_d = fuel_q - 8'd1;
          end else fuel_tmr_d = fuel_tmr_q + 8'd1;
        end
        if (32'(rpm_q) > 32'd3000)
          temp_d = (32'(temp_q) + 32'd2 > TEMP_MAX) ? 8'(TEMP_MAX) : temp_q + 8'd2;
        else if (temp_q > 8'd40) temp_d = temp_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= '0; rpm_q <= '0; gear_q <= GEAR_NONE; hold_q <= '0; was_d_q <= 1'b0;
      shift_q <= 1'b0; cact_q <= 1'b0; ctgt_q <= '0; ess_q <= 1'b0;
      fuel_q <= 8'd100; temp_q <= 8'd40; fuel_tmr_q <= '0; odo_cnt_q <= '0; odo_q <= '0;
    end else begin
      speed_q <= speed_d; rpm_q <= rpm_d; gear_q <= gear_d; hold_q <= hold_d; was_d_q <= was_d_d;
      shift_q <= shift_d; cact_q <= cact_d; ctgt_q <= ctgt_d; ess_q <= ess_d;
      fuel_q <= fuel_d; temp_q <= temp_d; fuel_tmr_q <= fuel_tmr_d; odo_cnt_q <= odo_cnt_d;
      odo_q <= odo_d;
    end
  end

  assign speed         = speed_q;
  assign rpm           = rpm_q;
  assign engaged_gear  = gear_q;
  assign shift_pulse   = shift_q;
  assign cruise_active = cact_q;
  assign cruise_target = ctgt_q;
  assign fuel          = fuel_q;
  assign fuel_empty    = (fuel_q == 8'd0);
  assign temp          = temp_q;
  assign odometer_raw  = odo_q;
  assign ess_trigger   = ess_q;
endmodule

// File: tb/tb_vehicle_dynamics_v2.sv
// Bench for vehicle_dynamics_v2: directed scenarios plus randomized traffic against
// an integer reference model of the vehicle rules.
`timescale 1ns/1ps
module tb_vehicle_dynamics_v2;
  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, engine_on, tick_1sec, tick_speed, is_brake_normal, is_brake_hard;
  logic        cruise_set, cruise_cancel;
  logic [3:0]  current_gear;
  logic [7:0]  adc_accel;
  logic [7:0]  speed, cruise_target, fuel, temp;
  logic [13:0] rpm;
  logic [2:0]  engaged_gear;
  logic        shift_pulse, cruise_active, fuel_empty, ess_trigger;
  logic [31:0] odometer_raw;

  vehicle_dynamics_v2 dut (
    .clk(clk), .rst(rst), .engine_on(engine_on), .tick_1sec(tick_1sec),
    .tick_speed(tick_speed), .current_gear(current_gear), .adc_accel(adc_accel),
    .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
    .cruise_set(cruise_set), .cruise_cancel(cruise_cancel),
    .speed(speed), .rpm(rpm), .engaged_gear(engaged_gear), .shift_pulse(shift_pulse),
    .cruise_active(cruise_active), .cruise_target(cruise_target), .fuel(fuel),
    .fuel_empty(fuel_empty), .temp(temp), .odometer_raw(odometer_raw),
    .ess_trigger(ess_trigger)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model
  int up_tab    [0:6] = '{0, 30, 60, 90, 130, 180, 0};
  int dn_tab    [0:6] = '{0, 0, 25, 55, 85, 125, 175};
  int rpm_base  [0:6] = '{800, 800, 1500, 1500, 1600, 1700, 1800};
  int rpm_low   [0:6] = '{0, 0, 30, 60, 90, 130, 180};
  int rpm_slope [0:6] = '{0, 90, 70, 50, 40, 30, 20};

  int m_speed = 0, m_rpm = 0, m_gear = 0, m_shift = 0, m_cact = 0, m_ctgt = 0;
  int m_fuel = 100, m_temp = 40, m_ess = 0, m_hold = 0, m_was_d = 0;
  int m_fuel_t = 0, m_odo_t = 0;
  longint m_odo = 0;

  function automatic int rpm_model(input int spd, input int g, input int ea);
    int r;
    if (g == 0) r = 800 + ea * 20;
    else r = rpm_base[g] + ((spd > rpm_low[g]) ? (spd - rpm_low[g]) * rpm_slope[g] : 0);
    return (r > 8000) ? 8000 : r;
  endfunction

  task automatic model_step();
    int ea, pw, rs, ceil_v;
    int n_speed, n_rpm, n_gear, n_cact, n_ctgt, n_fuel, n_temp, n_ess, n_hold, n_was_d;
    int n_fuel_t, n_odo_t;
    longint n_odo;
    bit dsel, rsel;
    n_speed = m_speed; n_rpm = m_rpm; n_gear = m_gear; n_cact = m_cact; n_ctgt = m_ctgt;
    n_fuel = m_fuel; n_temp = m_temp; n_ess = m_ess; n_hold = m_hold; n_was_d = m_was_d;
    n_fuel_t = m_fuel_t; n_odo_t = m_odo_t; n_odo = m_odo;
    m_shift = 0;
    dsel = (current_gear == 4'd12);
    rsel = (current_gear == 4'd6);
    ea = (int'(adc_accel) > 10 && m_fuel != 0) ? int'(adc_accel) : 0;
    if (rst) begin
      n_speed = 0; n_rpm = 0; n_gear = 0; n_cact = 0; n_ctgt = 0; n_fuel = 100; n_temp = 40;
      n_ess = 0; n_hold = 0; n_was_d = 0; n_fuel_t = 0; n_odo_t = 0; n_odo = 0;
    end else if (!engine_on) begin
      n_speed = 0; n_rpm = 0; n_gear = 0; n_cact = 0; n_ctgt = 0; n_ess = 0;
      n_hold = 0; n_was_d = 0;
    end else begin
      n_rpm = rpm_model(m_speed, m_gear, ea);
      if (tick_speed) begin
        pw = dsel ? ea : (rsel ? ea / 2 : 0);
        rs = m_speed / 4 + 2;
        ceil_v = rsel ? 50 : 250;
        if (is_brake_hard) begin
          n_ess = (m_speed > 50);
          n_speed = (m_speed > 8) ? m_speed - 8 : 0;
        end else begin
          n_ess = 0;
          if (is_brake_normal) n_speed = (m_speed > 3) ? m_speed - 3 : 0;
          else if (m_cact != 0 && ea == 0) begin
            if (m_speed < m_ctgt) n_speed = m_speed + 1;
            else if (m_speed > m_ctgt) n_speed = m_speed - 1;
          end else if (pw > rs) begin
            if (m_speed < ceil_v) n_speed = m_speed + 1;
          end else if (pw < rs) n_speed = (m_speed > 0) ? m_speed - 1 : 0;
        end
        if (dsel) begin
          if (m_was_d == 0) begin n_gear = 1; n_hold = 0; end
          else if (m_hold > 0) n_hold = m_hold - 1;
          else if (m_gear < 6 && m_speed >= up_tab[m_gear]) begin
            n_gear = m_gear + 1; n_hold = 4; m_shift = 1;
          end else if (m_gear > 1 && m_speed < dn_tab[m_gear]) begin
            n_gear = m_gear - 1; n_hold = 4; m_shift = 1;
          end
        end else begin
          n_gear = rsel ? 1 : 0;
          n_hold = 0;
        end
        n_was_d = dsel;
      end
      if (cruise_cancel || is_brake_normal || is_brake_hard || !dsel) n_cact = 0;
      else if (cruise_set && m_speed >= 30) begin n_cact = 1; n_ctgt = m_speed; end
      if (tick_1sec) begin
        if (m_odo_t == 9) begin n_odo_t = 0; n_odo = (m_odo + m_speed) % (64'd1 << 32); end
        else n_odo_t = m_odo_t + 1;
        if (m_speed > 0 || m_rpm > 1000) begin
          if (m_fuel_t == 2) begin n_fuel_t = 0; n_fuel = (m_fuel > 0) ? m_fuel - 1 : 0; end
          else n_fuel_t = m_fuel_t + 1;
        end
        if (m_rpm > 3000) n_temp = (m_temp + 2 > 200) ? 200 : m_temp + 2;
        else if (m_temp > 40) n_temp = m_temp - 1;
      end
    end
    m_speed = n_speed; m_rpm = n_rpm; m_gear = n_gear; m_cact = n_cact; m_ctgt = n_ctgt;
    m_fuel = n_fuel; m_temp = n_temp; m_ess = n_ess; m_hold = n_hold; m_was_d = n_was_d;
    m_fuel_t = n_fuel_t; m_odo_t = n_odo_t; m_odo = n_odo;
  endtask

  // driver tasks
  int tick_no = 0, pulse_cnt = 0, last_pulse_tick = 0, prev_pulse_tick = 0;

  task automatic step();
    logic [7:0] exp_speed;
    if (tick_speed) tick_no++;
    @(posedge clk);
    model_step();
    exp_q.push_back(8'(m_speed));
    #1;
    exp_speed = exp_q.pop_front();
    check_eq("speed", speed, exp_speed);
    check_eq("rpm", rpm, m_rpm);
    check_eq("engaged_gear", engaged_gear, m_gear);
    check_eq("shift_pulse", shift_pulse, m_shift);
    check_eq("cruise_active", cruise_active, m_cact);
    check_eq("cruise_target", cruise_target, m_ctgt);
    check_eq("fuel", fuel, m_fuel);
    check_eq("fuel_empty", fuel_empty, (m_fuel == 0));
    check_eq("temp", temp, m_temp);
    check_eq("odometer_raw", odometer_raw, m_odo);
    check_eq("ess_trigger", ess_trigger, m_ess);
    if (shift_pulse === 1'b1) begin
      pulse_cnt++;
      prev_pulse_tick = last_pulse_tick;
      last_pulse_tick = tick_no;
    end
  endtask

  task automatic clear_strobes();
    tick_speed = 1'b0; tick_1sec = 1'b0; is_brake_normal = 1'b0; is_brake_hard = 1'b0;
    cruise_set = 1'b0; cruise_cancel = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_speed = 1'b1; step();
      clear_strobes(); step();
    end
  endtask

  task automatic brake_tick(input bit hard);
    if (hard) is_brake_hard = 1'b1; else is_brake_normal = 1'b1;
    ticks(1);
  endtask

  task automatic secs(input int n);
    repeat (n) begin
      tick_1sec = 1'b1; step();
      clear_strobes(); step();
    end
  endtask

  task automatic do_reset();
    clear_strobes();
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
  endtask

  logic [3:0] sel_tab [0:7] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd12, 4'd12, 4'd0, 4'd15};

  initial begin
    clear_strobes();
    rst = 1'b1; engine_on = 1'b1; current_gear = 4'd12; adc_accel = 8'd0;
    step();
    check_eq("reset_speed", speed, 0);
    check_eq("reset_fuel", fuel, 100);
    check_eq("reset_temp", temp, 40);
    check_eq("reset_gear", engaged_gear, 0);
    rst = 1'b0;

    // Plan 1: launch in D
    adc_accel = 8'd200; pulse_cnt = 0;
    ticks(40);
    check_eq("p1_speed", speed, 40);
    check_eq("p1_gear", engaged_gear, 2);
    check_eq("p1_pulses", pulse_cnt, 1);

    // Plan 2: hard brake from 60, deadzone
    ticks(20);
    check_eq("p2_speed60", speed, 60);
    brake_tick(1'b1);
    check_eq("p2_hard_speed", speed, 52);
    check_eq("p2_ess_set", ess_trigger, 1);
    adc_accel = 8'd10;
    ticks(1);
    check_eq("p2_ess_clr", ess_trigger, 0);
    check_eq("p2_deadzone", speed, 51);

    // Plan 3: reverse ceiling
    do_reset();
    current_gear = 4'd6; adc_accel = 8'd255;
    ticks(80);
    check_eq("p3_speed", speed, 50);
    check_eq("p3_gear", engaged_gear, 1);
    check_eq("p3_rpm", rpm, 5300);

    // Plan 4: cruise
    do_reset();
    current_gear = 4'd12; adc_accel = 8'd200;
    ticks(40);
    cruise_set = 1'b1; step(); clear_strobes(); step();
    check_eq("p4_active", cruise_active, 1);
    check_eq("p4_target", cruise_target, 40);
    adc_accel = 8'd0;
    ticks(5);
    check_eq("p4_hold_speed", speed, 40);
    is_brake_normal = 1'b1; step(); clear_strobes(); step();
    check_eq("p4_brake_cancel", cruise_active, 0);
    cruise_set = 1'b1; cruise_cancel = 1'b1; step(); clear_strobes(); step();
    check_eq("p4_set_cancel", cruise_active, 0);
    check_eq("p4_target_kept", cruise_target, 40);

    // Plan 5: odometer and fuel starvation
    do_reset();
    current_gear = 4'd12; adc_accel = 8'd200;
    ticks(20);
    secs(30);
    check_eq("p5_odo", odometer_raw, 60);
    check_eq("p5_fuel", fuel, 90);
    secs(270);
    check_eq("p5_fuel0", fuel, 0);
    check_eq("p5_empty", fuel_empty, 1);
    check_eq("p5_odo600", odometer_raw, 600);
    adc_accel = 8'd255;
    ticks(30);
    check_eq("p5_decay", speed, 0);

    // Plan 6: oscillation around the 1->2 threshold
    do_reset();
    current_gear = 4'd12; adc_accel = 8'd200;
    ticks(29);
    pulse_cnt = 0;
    repeat (5) begin ticks(2); brake_tick(1'b0); end
    check_eq("p6_gear", engaged_gear, 2);
    check_eq("p6_pulses", pulse_cnt, 1);
    brake_tick(1'b0);
    check_eq("p6_down_gear", engaged_gear, 1);
    check_eq("p6_down_pulses", pulse_cnt, 2);

    // Shift hold-off: downshift waits out the lock-out
    do_reset();
    current_gear = 4'd12; adc_accel = 8'd200;
    pulse_cnt = 0;
    ticks(31);
    brake_tick(1'b1);
    repeat (4) brake_tick(1'b0);
    check_eq("hold_pulses", pulse_cnt, 2);
    check_eq("hold_gap", last_pulse_tick - prev_pulse_tick, 5);
    check_eq("hold_gear", engaged_gear, 1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 2) engine_on = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 2) current_gear = sel_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 99) < 6) adc_accel = 8'($urandom_range(0, 255));
      tick_speed      = ($urandom_range(0, 1) == 1);
      tick_1sec       = ($urandom_range(0, 7) == 0);
      is_brake_normal = ($urandom_range(0, 39) == 0);
      is_brake_hard   = ($urandom_range(0, 59) == 0);
      cruise_set      = ($urandom_range(0, 19) == 0);
      cruise_cancel   = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    clear_strobes();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
